// File: rtl/pg_sum_serializer.sv
// pg_sum_serializer: last stage of the Brent-Kung adder. It takes the
// propagate and prefix-generate bits, captures sum = P ^ G together with the
// carry-out, and streams the sum LSB first in LANE-bit beats under
// valid/ready backpressure.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SEND  | presenting beat out_idx of the captured sum, out_valid=1
module pg_sum_serializer #(
    parameter int WIDTH = 64,
    parameter int LANE  = 16,
    localparam int BEATS = WIDTH / LANE,
    localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH:0]   in_g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANE-1:0]  out_sum,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    // The captured sum is shifted right one lane per accepted beat, so the
    // current beat always sits in the low LANE bits and drains to zero.
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_sum   = sum_q[LANE-1:0];

    // Capture the operand, then step through the beats on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            out_idx  <= '0;
            out_last <= 1'b0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SEND;
                        sum_q    <= in_p ^ in_g[WIDTH-1:0];
                        cout_q   <= in_g[WIDTH];
                        out_idx  <= '0;
                        out_last <= (BEATS == 1);
                        out_cout <= (BEATS == 1) && in_g[WIDTH];
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        sum_q <= sum_q >> LANE;
                        if (out_last) begin
                            state    <= IDLE;
                            cout_q   <= 1'b0;
                            out_idx  <= '0;
                            out_last <= 1'b0;
                            out_cout <= 1'b0;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_last <= (int'(out_idx) + 2 == BEATS);
                            out_cout <= cout_q && (int'(out_idx) + 2 == BEATS);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
